data_ram: RTL
=============

# data_ram

Data memory behind the load/store stage of the single-cycle RV64 core. Accepts doubleword-aligned addresses with per-byte write enables, returns the full 64-bit doubleword combinationally for loads in the same cycle, and commits stores at the clock edge. After reset it runs a clear sweep that zeroes every word, then asserts ready. It flags out-of-range accesses, suppressing them.

## Interface
Parameters:
- DEPTH, 4096: number of 64-bit words; power of two, ≥ 2.
- BASE_ADDR, 64'h0000_0000_8000_0000: byte address of word 0; 8-byte aligned.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ram_addr_i  input  XLEN  byte address; bits [2:0] are zero from the load/store stage and are ignored.
- ram_ren_i  input  1  load request this cycle.
- ram_rdata_o  output  XLEN  doubleword at ram_addr_i; combinational.
- ram_wen_i  input  1  store request this cycle.
- ram_byte_en_i  input  8  bit k enables byte lane k (bits [8k+7:8k]).
- ram_wdata_i  input  XLEN  store data, already lane-positioned.
- ram_ready_o  output  1  clear sweep complete; accesses honoured.
- ram_err_o  output  1  combinational: current request is out of range.
- ram_err_sticky_o  output  1  registered: set by any out-of-range request, cleared only by reset.

## Operation
- Word index = (ram_addr_i − BASE_ADDR) >> 3, truncated to clog2(DEPTH) bits.
- In range iff BASE_ADDR ≤ ram_addr_i < BASE_ADDR + 8·DEPTH, compared at full XLEN; no wrap-around aliasing.
- Read: ram_rdata_o = mem[index] when ram_ren_i, ram_ready_o and in range; otherwise 0.
- Write: at posedge, when ram_wen_i, ram_ready_o and in range, each lane with byte_en bit set gets the matching ram_wdata_i byte; other lanes unchanged. byte_en = 0 with wen is a legal no-op.
- ram_err_o = (ram_ren_i | ram_wen_i) & ~in_range, regardless of ready. Out-of-range store modifies nothing.
- ram_ren_i and ram_wen_i both high: read returns pre-write contents; write commits at edge.
- FSM states: CLEAR, READY. Reset → CLEAR, counter = 0. CLEAR: each cycle write 0 to mem[counter], counter++; on counter = DEPTH−1 write it and go to READY. READY is terminal until reset.
- During CLEAR: requests ignored, ram_rdata_o = 0, ram_err_o still computed, sticky still updates.

## Timing
- Reset values: ram_ready_o 0, ram_err_sticky_o 0, state CLEAR, counter 0; ram_rdata_o 0 (ready low); ram_err_o combinational from inputs.
- Reset assertion mid-sweep or in READY: immediate return to CLEAR, counter 0; sweep restarts.
- ram_ready_o rises exactly DEPTH rising edges after rst_n deasserts.
- Load latency 0 cycles (combinational); store visible to a load in the following cycle.
- ram_err_sticky_o rises at the edge after the first erroneous request.
- Memory array itself not reset; only the sweep initialises it.

## Configuration
- DATA_RAM_CLEAR_EN defined: sweep as above.
- Undefined: no FSM or counter; ram_ready_o tied 1 from reset; contents undefined (simulation X) until written; all other behaviour identical.

## Structure
- Shared defines package: XLEN, default BASE_ADDR, CLEAR/READY state encoding.
- Single module; the array with byte-lane write is a natural sub-module data_ram_array (DEPTH×64, 8 lane enables, async read, one write port muxed between sweep and store).

## Test plan
- Reset with DEPTH=16, macro on → ram_ready_o low for 16 cycles, high on the 16th edge; every address BASE..BASE+0x78 then reads 0.
- Store 0x1122334455667788, byte_en 0xFF, at BASE+0x8; then byte_en 0x02, data 0xAB00 → load of BASE+0x8 returns 0x112233445566AB88.
- Simultaneous ren+wen to BASE+0x10 (holding 0) with 0xFF data → rdata 0 that cycle, 0xFF next cycle.
- Load at BASE+8·DEPTH and at BASE−8 → ram_err_o 1, rdata 0; sticky high next edge and stays; store out of range leaves all words unchanged.
- Assert rst_n low mid-sweep (counter 7) → ready stays low, full 16-cycle sweep restarts; sticky cleared.
- Macro off → ram_ready_o 1 at first edge after reset; store/load at BASE round-trips immediately.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared definitions for the RV64 data memory: datapath width, default base address
// and the clear-sweep state encoding.
package data_ram_pkg;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/data_ram_array.sv
// DEPTH x 64-bit storage with asynchronous read and a single byte-lane-masked write port.
// The array is deliberately not reset; initialisation is the owner's job.
module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [7:0]      be,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_ram.sv
// Data memory for the load/store stage: combinational loads, edge-committed byte stores,
// range checking. Define DATA_RAM_CLEAR_EN to zero the array with a sweep after reset.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int              DEPTH     = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ram_addr_i,
  input  logic            ram_ren_i,
  output logic [XLEN-1:0] ram_rdata_o,
  input  logic            ram_wen_i,
  input  logic [7:0]      ram_byte_en_i,
  input  logic [XLEN-1:0] ram_wdata_i,
  output logic            ram_ready_o,
  output logic            ram_err_o,
  output logic            ram_err_sticky_o
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so the upper bound cannot wrap when the window sits near the top of memory
  localparam logic [XLEN:0] END_ADDR = {1'b0, BASE_ADDR} + ((XLEN+1)'(DEPTH) << 3);

  logic            in_range;
  logic [AW-1:0]   word_idx;
  logic            ready;
  logic            store_ok;
  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [7:0]      arr_be;
  logic [XLEN-1:0] arr_wdata;
  logic [XLEN-1:0] arr_rdata;
  logic            err_sticky_q;

  assign in_range = (ram_addr_i >= BASE_ADDR) && ({1'b0, ram_addr_i} < END_ADDR);
  assign word_idx = AW'((ram_addr_i - BASE_ADDR) >> 3);
  assign store_ok = ram_wen_i & ready & in_range;

`ifdef DATA_RAM_CLEAR_EN
  ram_state_e    state;
  logic [AW-1:0] clr_cnt;
  logic          ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // While sweeping, the write port belongs to the clear counter; stores are dropped
  assign ready     = ready_q;
  assign arr_we    = (state == CLEAR) | store_ok;
  assign arr_waddr = (state == CLEAR) ? clr_cnt : word_idx;
  assign arr_be    = (state == CLEAR) ? 8'hFF : ram_byte_en_i;
  assign arr_wdata = (state == CLEAR) ? '0 : ram_wdata_i;
`else
  assign ready     = 1'b1;
  assign arr_we    = store_ok;
  assign arr_waddr = word_idx;
  assign arr_be    = ram_byte_en_i;
  assign arr_wdata = ram_wdata_i;
`endif

  data_ram_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .be    (arr_be),
    .wdata (arr_wdata),
    .raddr (word_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_sticky_q <= 1'b0;
    else if (ram_err_o) err_sticky_q <= 1'b1;
  end

  assign ram_err_o        = (ram_ren_i | ram_wen_i) & ~in_range;
  assign ram_rdata_o      = (ram_ren_i & ready & in_range) ? arr_rdata : '0;
  assign ram_ready_o      = ready;
  assign ram_err_sticky_o = err_sticky_q;

endmodule
